// File: rtl/block_pixel_scanner_if.sv
// Command/pixel stream bundle for the block pixel scanner.
// master = command/pixel driver side, slave = scanner side.
interface block_pixel_scanner_if #(
  parameter int COLOR_W = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [11:0]        cmd_addr;
  logic [COLOR_W-1:0] cmd_color;
  logic               abort;
  logic               pix_valid;
  logic               pix_ready;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_last;
  logic               busy;
  logic               err_oob;

  modport master (
    output cmd_valid, cmd_addr, cmd_color, abort, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last, busy, err_oob
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_color, abort, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_color, pix_last, busy, err_oob
  );
endinterface

// File: rtl/block_pixel_scanner.sv
// Expands a 16x16 block address into its 256 pixel coordinates in raster order.
// Out-of-area blocks are rejected with a one-cycle err_oob pulse.
module block_pixel_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COLOR_W  = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  block_pixel_scanner_if.slave bus
);
  localparam logic [5:0] XB_LIM = 6'(H_ACTIVE / 16);
  localparam logic [5:0] YB_LIM = 6'(V_ACTIVE / 16);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_nxt;
  logic [3:0]         col, row;
  logic [5:0]         xb, yb;
  logic [COLOR_W-1:0] color;
  logic               err_q;

  logic oob, accept, xfer, at_last;

  assign oob     = (bus.cmd_addr[5:0] >= XB_LIM) || (bus.cmd_addr[11:6] >= YB_LIM);
  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign xfer    = (state == SCAN) && bus.pix_ready;
  assign at_last = (col == 4'hF) && (row == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort wins over everything in SCAN; a coincident transfer still counts
  // because the beat is already on the bus and accepted downstream.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !oob)                  state_nxt = SCAN;
      SCAN: if (bus.abort || (xfer && at_last))  state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      xb    <= '0;
      yb    <= '0;
      color <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && oob;
      if (accept && !oob) begin
        xb    <= bus.cmd_addr[5:0];
        yb    <= bus.cmd_addr[11:6];
        color <= bus.cmd_color;
        col   <= '0;
        row   <= '0;
      end else if (xfer) begin
        col <= col + 4'd1;
        if (col == 4'hF) row <= row + 4'd1;
      end
    end
  end

  // Coordinates are plain concatenations: block index in the high bits.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state == SCAN);
  assign bus.pix_valid = (state == SCAN);
  assign bus.pix_x     = {xb, col};
  assign bus.pix_y     = {yb, row};
  assign bus.pix_color = color;
  assign bus.pix_last  = (state == SCAN) && at_last;
  assign bus.err_oob   = err_q;
endmodule

// File: tb/tb_block_pixel_scanner.sv
// Directed bench for block_pixel_scanner: raster order, bounds, stalls, abort, reset.
module tb_block_pixel_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  block_pixel_scanner_if #(.COLOR_W(6)) bus ();

  block_pixel_scanner #(.H_ACTIVE(640), .V_ACTIVE(480), .COLOR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [11:0] addr, input logic [5:0] col_in);
    bus.cmd_addr  = addr;
    bus.cmd_color = col_in;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_color = 0;
    bus.abort = 0; bus.pix_ready = 1;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.err_oob !== 1'b0 || bus.pix_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b err=%b last=%b required 1 0 0 0 0",
               bus.cmd_ready, bus.pix_valid, bus.busy, bus.err_oob, bus.pix_last);
    end
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd0 || bus.pix_color !== 6'd0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d c=%h required 0 0 0", bus.pix_x, bus.pix_y, bus.pix_color);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_origin();
    int beats = 0, cyc = 0;
    bus.pix_ready = 1'b1;
    send_cmd(12'h000, 6'h03);
    checks++;
    if (bus.pix_valid !== 1'b1) begin
      errors++; $display("FAIL origin_latency got pix_valid=%b required 1", bus.pix_valid);
    end
    while (bus.pix_valid === 1'b1 && cyc < 400) begin
      checks++;
      if (bus.pix_x !== 10'(beats % 16) || bus.pix_y !== 10'(beats / 16)) begin
        errors++;
        $display("FAIL origin_xy beat=%0d got (%0d,%0d) required (%0d,%0d)",
                 beats, bus.pix_x, bus.pix_y, beats % 16, beats / 16);
      end
      checks++;
      if (bus.pix_last !== (beats == 255)) begin
        errors++; $display("FAIL origin_last beat=%0d got %b required %b", beats, bus.pix_last, beats == 255);
      end
      @(posedge clk); #1;
      beats++; cyc++;
    end
    checks++;
    if (beats != 256) begin
      errors++; $display("FAIL origin_count got %0d required 256", beats);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL origin_ready_after got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_corner();
    int beats = 0, cyc = 0, inv;
    bus.pix_ready = 1'b1;
    send_cmd(12'h767, 6'h11);
    while (bus.pix_valid === 1'b1 && cyc < 400) begin
      checks++;
      if (bus.pix_x !== 10'(624 + beats % 16) || bus.pix_y !== 10'(464 + beats / 16)) begin
        errors++;
        $display("FAIL corner_xy beat=%0d got (%0d,%0d) required (%0d,%0d)",
                 beats, bus.pix_x, bus.pix_y, 624 + beats % 16, 464 + beats / 16);
      end
      inv = (int'(bus.pix_y) >> 4) * 64 + (int'(bus.pix_x) >> 4);
      checks++;
      if (inv != 'h767) begin
        errors++; $display("FAIL corner_invariant beat=%0d got %h required 767", beats, inv);
      end
      checks++;
      if (bus.pix_last !== (beats == 255)) begin
        errors++; $display("FAIL corner_last beat=%0d got %b required %b", beats, bus.pix_last, beats == 255);
      end
      @(posedge clk); #1;
      beats++; cyc++;
    end
    checks++;
    if (beats != 256) begin
      errors++; $display("FAIL corner_count got %0d required 256", beats);
    end
  endtask

  task automatic test_oob();
    logic [11:0] addrs [2] = '{12'h028, 12'h780};
    foreach (addrs[i]) begin
      send_cmd(addrs[i], 6'h3F);
      checks++;
      if (bus.err_oob !== 1'b1 || bus.pix_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL oob_pulse addr=%h got err=%b vld=%b rdy=%b required 1 0 1",
                 addrs[i], bus.err_oob, bus.pix_valid, bus.cmd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err_oob !== 1'b0 || bus.pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL oob_one_cycle addr=%h got err=%b vld=%b required 0 0", addrs[i], bus.err_oob, bus.pix_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int beats = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [9:0] sx = 0, sy = 0;
    logic [5:0] sc = 0;
    logic sl = 0, r;
    send_cmd(12'h041, 6'h2A);
    bus.cmd_color = 6'h15;
    while (bus.pix_valid === 1'b1 && cyc < 3000) begin
      if (stalled) begin
        checks++;
        if (bus.pix_x !== sx || bus.pix_y !== sy || bus.pix_color !== sc || bus.pix_last !== sl) begin
          errors++;
          $display("FAIL bp_hold beat=%0d got (%0d,%0d,%h,%b) required (%0d,%0d,%h,%b)",
                   beats, bus.pix_x, bus.pix_y, bus.pix_color, bus.pix_last, sx, sy, sc, sl);
        end
      end
      checks++;
      if (bus.pix_x !== 10'(16 + beats % 16) || bus.pix_y !== 10'(16 + beats / 16) || bus.pix_color !== 6'h2A) begin
        errors++;
        $display("FAIL bp_beat beat=%0d got (%0d,%0d,%h) required (%0d,%0d,2a)",
                 beats, bus.pix_x, bus.pix_y, bus.pix_color, 16 + beats % 16, 16 + beats / 16);
      end
      r = 1'($urandom_range(0, 1));
      bus.pix_ready = r;
      sx = bus.pix_x; sy = bus.pix_y; sc = bus.pix_color; sl = bus.pix_last;
      stalled = !r;
      @(posedge clk); #1;
      if (r) beats++;
      cyc++;
    end
    bus.pix_ready = 1'b1;
    checks++;
    if (beats != 256) begin
      errors++; $display("FAIL bp_count got %0d required 256", beats);
    end
  endtask

  task automatic test_abort();
    int beats = 0, cyc = 0;
    bus.pix_ready = 1'b1;
    send_cmd(12'h085, 6'h07);
    while (beats < 20 && cyc < 100) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_x !== 10'(80 + beats % 16) || bus.pix_y !== 10'(32 + beats / 16)) begin
        errors++;
        $display("FAIL abort_beat beat=%0d got vld=%b (%0d,%0d) required 1 (%0d,%0d)",
                 beats, bus.pix_valid, bus.pix_x, bus.pix_y, 80 + beats % 16, 32 + beats / 16);
      end
      if (beats == 19) bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      beats++; cyc++;
    end
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_stop got vld=%b busy=%b rdy=%b required 0 0 1", bus.pix_valid, bus.busy, bus.cmd_ready);
    end
    @(posedge clk); #1;
    send_cmd(12'h085, 6'h07);
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_x !== 10'd80 || bus.pix_y !== 10'd32) begin
      errors++;
      $display("FAIL abort_restart got vld=%b (%0d,%0d) required 1 (80,32)", bus.pix_valid, bus.pix_x, bus.pix_y);
    end
    bus.pix_ready = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.pix_ready = 1'b1;
    checks++;
    if (bus.pix_valid !== 1'b0) begin
      errors++; $display("FAIL abort_stalled got vld=%b required 0", bus.pix_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int beats = 0, cyc = 0;
    bus.pix_ready = 1'b1;
    send_cmd(12'h041, 6'h01);
    while (beats < 100 && cyc < 200) begin
      @(posedge clk); #1;
      beats++; cyc++;
    end
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_x !== 10'd20 || bus.pix_y !== 10'd22) begin
      errors++;
      $display("FAIL rst_pre got vld=%b (%0d,%0d) required 1 (20,22)", bus.pix_valid, bus.pix_x, bus.pix_y);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pix_last !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got vld=%b busy=%b last=%b rdy=%b required 0 0 0 1",
               bus.pix_valid, bus.busy, bus.pix_last, bus.cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(12'h767, 6'h02);
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_x !== 10'd624 || bus.pix_y !== 10'd464 || bus.pix_color !== 6'h02) begin
      errors++;
      $display("FAIL rst_restart got vld=%b (%0d,%0d,%h) required 1 (624,464,02)",
               bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color);
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_origin();
    test_corner();
    test_oob();
    test_backpressure();
    test_abort();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_pixel_scanner.md
Name: block_pixel_scanner

Overview:
- Inverse of the pixel-to-block address mapping. Accepts a 12-bit block address, address = (y>>4)*64 + (x>>4), and emits every (x,y) pixel coordinate of that 16x16 block in raster order over a valid/ready stream.
- Sits between the Arduino command decoder and the framebuffer/block-fill writer in the VGA GPU. Used for block fills and block redraws.
- Rejects blocks outside the 640x480 active area.

Parameters:
- H_ACTIVE, 640, active pixels per line; valid x_block range is 0..H_ACTIVE/16-1.
- V_ACTIVE, 480, active lines; valid y_block range is 0..V_ACTIVE/16-1.
- COLOR_W, 6, width of the colour field carried with the command (2-bit R, G, B).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  block command present.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  12  block address; [5:0]=x_block, [11:6]=y_block.
- cmd_color  in  COLOR_W  colour attached to every emitted pixel.
- abort  in  1  synchronous cancel of the scan in progress.
- pix_valid  out  1  pix_x/pix_y/pix_color/pix_last valid.
- pix_ready  in  1  downstream accepts the beat.
- pix_x  out  10  pixel column.
- pix_y  out  10  pixel row.
- pix_color  out  COLOR_W  latched cmd_color.
- pix_last  out  1  high on the final beat of the block (col=15, row=15).
- busy  out  1  high while in SCAN.
- err_oob  out  1  one-cycle pulse when an out-of-bounds command is rejected.

Behaviour:
- Reset (async assert, sync release): state=IDLE; col=0, row=0. All outputs 0 except cmd_ready, which is 1 in IDLE after reset.
- Two states, IDLE and SCAN.
- IDLE:
  - cmd_ready=1, pix_valid=0, busy=0.
  - Handshake happens when cmd_valid & cmd_ready are both high at a rising edge.
  - If cmd_addr[5:0] >= H_ACTIVE/16 (40) or cmd_addr[11:6] >= V_ACTIVE/16 (30): err_oob=1 for exactly the next cycle, state stays IDLE, nothing emitted.
  - Otherwise: latch x_block, y_block and colour; col=0, row=0; go to SCAN.
- Latency: first pix_valid is high in the cycle immediately after the accepting edge.
- SCAN:
  - cmd_ready=0, busy=1, pix_valid=1.
  - pix_x = {x_block, col[3:0]}, pix_y = {y_block, row[3:0]}; pure concatenation, no adder needed.
  - A beat transfers when pix_valid & pix_ready.
  - On transfer: col+1. When col=15, col wraps to 0 and row increments.
  - On transfer with col=15 and row=15 (pix_last=1): go to IDLE. cmd_ready rises the next cycle, so there is no back-to-back command acceptance in the same cycle.
  - Exactly 256 beats per block. Throughput is 1 beat/clk with pix_ready held high, so 256 cycles.
- Backpressure: while pix_valid & !pix_ready, pix_x, pix_y, pix_color and pix_last are held stable.
- abort:
  - Sampled in SCAN only; ignored in IDLE.
  - Next state is IDLE with pix_valid=0 the following cycle.
  - If abort and a transfer coincide, that beat counts as delivered and no further beats are emitted.
  - Abort on the last beat behaves as normal completion.
- cmd_color changes while busy have no effect.
- Reset mid-SCAN: outputs go to reset values immediately (asynchronously). The scan is lost, and the block is in IDLE on release.
- Invariant for every beat: ((pix_y>>4)<<6) + (pix_x>>4) == the accepted cmd_addr.

Test Plan:
- cmd_addr=0x000, pix_ready=1 → 256 beats, first (0,0), 16th (15,0), 17th (0,1), last (15,15) with pix_last=1. cmd_ready returns 1 one cycle after the last beat.
- cmd_addr=0x767 (y_block 29, x_block 39) → first beat (624,464), last (639,479), pix_last only on the last beat, invariant holds on all 256 beats.
- cmd_addr=0x028 (x_block 40), then 0x780 (y_block 30) → err_oob one-cycle pulse each, pix_valid stays 0, cmd_ready stays 1.
- cmd_addr=0x041, cmd_color=0x2A, pix_ready random ~50% → outputs stable while stalled, exactly 256 unique beats, pix_color=0x2A on all beats, coordinates x 16..31, y 16..31.
- Abort asserted together with the transfer of beat 20 → exactly 20 beats delivered, pix_valid=0 next cycle, a new command accepted 2 cycles later starts again at (block origin).
- rst_n pulsed low at beat 100 → pix_valid, busy and pix_last go to 0 without waiting for a clock edge. After release a new command scans from col=0, row=0.
